// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes of the integer ALU and the multiply
// sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [2:0] {
        MUL_IDLE,
        MUL_ADD,
        MUL_SHL,
        MUL_SHR,
        MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU via alu_req/alu_gnt.
// Define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the multiplier shifts to zero.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplr_q, mplr_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic            alu_req_q, alu_req_d;
    logic [XLEN-1:0] alu_in1_q, alu_in1_d;
    logic [XLEN-1:0] alu_in2_q, alu_in2_d;
    logic [3:0]      alu_op_q, alu_op_d;

    logic last_iter;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_LAST) || alu_zero;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign last_iter       = (cnt_q == CNT_LAST);
`endif

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (in_valid) begin
                    mcand_d = in_a;
                    mplr_d  = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL_ADD;
                end
            end
            MUL_ADD: begin
                if (alu_gnt) begin
                    acc_d   = alu_result;
                    state_d = MUL_SHL;
                end
            end
            MUL_SHL: begin
                if (alu_gnt) begin
                    mcand_d = alu_result;
                    state_d = MUL_SHR;
                end
            end
            MUL_SHR: begin
                if (alu_gnt) begin
                    mplr_d  = alu_result;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_iter ? MUL_DONE : MUL_ADD;
                end
            end
            MUL_DONE: begin
                if (out_ready) state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Outputs are derived from the next-cycle register values and then
    // registered, so they change only on clock edges and hold during stalls.
    always_comb begin
        in_ready_d   = (state_d == MUL_IDLE);
        out_valid_d  = (state_d == MUL_DONE);
        out_result_d = (state_d == MUL_DONE) ? acc_d : '0;
        alu_req_d    = 1'b0;
        alu_op_d     = ALU_ADD;
        alu_in1_d    = '0;
        alu_in2_d    = '0;
        unique case (state_d)
            MUL_ADD: begin
                alu_req_d = 1'b1;
                alu_op_d  = ALU_ADD;
                alu_in1_d = acc_d;
                alu_in2_d = mplr_d[0] ? mcand_d : '0;
            end
            MUL_SHL: begin
                alu_req_d = 1'b1;
                alu_op_d  = ALU_SLL;
                alu_in1_d = mcand_d;
                alu_in2_d = XLEN'(1);
            end
            MUL_SHR: begin
                alu_req_d = 1'b1;
                alu_op_d  = ALU_SRL;
                alu_in1_d = mplr_d;
                alu_in2_d = XLEN'(1);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MUL_IDLE;
            mcand_q      <= '0;
            mplr_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            alu_req_q    <= 1'b0;
            alu_op_q     <= ALU_ADD;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplr_q       <= mplr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            alu_req_q    <= alu_req_d;
            alu_op_q     <= alu_op_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign alu_req    = alu_req_q;
    assign alu_op     = alu_op_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: a behavioural ALU, a table of directed
// products, multi-cycle corner sequences and randomized runs against a*b.
module tb_alu_mul_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a, in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            alu_req;
    logic            alu_gnt;
    logic [XLEN-1:0] alu_in1, alu_in2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Behavioural stand-in for the shared integer ALU.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_in1 + alu_in2;
            4'b0001: alu_result = alu_in1 - alu_in2;
            4'b0010: alu_result = alu_in1 << alu_in2[4:0];
            4'b0011: alu_result = XLEN'($signed(alu_in1) < $signed(alu_in2));
            4'b0100: alu_result = XLEN'(alu_in1 < alu_in2);
            4'b0101: alu_result = alu_in1 ^ alu_in2;
            4'b0110: alu_result = alu_in1 >> alu_in2[4:0];
            4'b0111: alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            4'b1000: alu_result = alu_in1 | alu_in2;
            4'b1001: alu_result = alu_in1 & alu_in2;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycles from the accept edge to the first cycle out_valid is seen,
    // with the grant held high throughout.
    function automatic int exp_lat(input logic [XLEN-1:0] b);
        int k;
        k = 1;
        for (int i = 0; i < XLEN; i++)
            if (b[i]) k = i + 1;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        return 3 * k + 1;
`else
        return 3 * XLEN + 1;
`endif
    endfunction

    // mode 0: grant always, 1: grant withheld every other requested cycle
    // (first one withheld), 2: random grant.
    task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int mode,
                           output logic [XLEN-1:0] res, output int lat, output int req_cycles,
                           output bit stable_ok);
        int n;
        bit phase, stalled;
        logic [XLEN-1:0] p1, p2;
        logic [3:0] pop;
        @(negedge clk);
        check("in_ready_before_accept", XLEN'(in_ready), XLEN'(1));
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1; req_cycles = 0; phase = 1'b0; stalled = 1'b0; stable_ok = 1'b1;
        p1 = '0; p2 = '0; pop = '0;
        while (!out_valid && n <= 1000) begin
            if (alu_req) begin
                req_cycles++;
                if (stalled && (alu_in1 !== p1 || alu_in2 !== p2 || alu_op !== pop))
                    stable_ok = 1'b0;
                p1 = alu_in1; p2 = alu_in2; pop = alu_op;
                case (mode)
                    0:       alu_gnt = 1'b1;
                    1:       begin alu_gnt = phase; phase = ~phase; end
                    default: alu_gnt = 1'($urandom_range(0, 1));
                endcase
                stalled = !alu_gnt;
            end else begin
                alu_gnt = 1'b0;
                stalled = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        alu_gnt = 1'b0;
        if (n > 1000) begin
            errors++;
            checks++;
            $display("FAIL timeout: no out_valid after %0d cycles", n);
        end
        lat = n;
        res = out_result;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_take_in_ready", XLEN'(in_ready), XLEN'(1));
        check("idle_after_take_out_valid", XLEN'(out_valid), XLEN'(0));
    endtask

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [XLEN-1:0] res, a, b;
        int lat, reqc;
        bit stok;

        vecs[0] = '{32'd7,        32'd6,        32'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[3] = '{32'd5,        32'd1,        32'd5};
        vecs[4] = '{32'd9,        32'd0,        32'd0};
        vecs[5] = '{32'd3,        32'h80000000, 32'h80000000};
        vecs[6] = '{32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; alu_gnt = 1'b0;
        #1;
        check("reset_in_ready", XLEN'(in_ready), XLEN'(1));
        check("reset_out_valid", XLEN'(out_valid), XLEN'(0));
        check("reset_alu_req", XLEN'(alu_req), XLEN'(0));
        check("reset_alu_op", XLEN'(alu_op), XLEN'(0));
        check("reset_alu_in1", alu_in1, '0);
        check("reset_alu_in2", alu_in2, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed table, grant always high.
        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, 0, res, lat, reqc, stok);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), XLEN'(lat), XLEN'(exp_lat(vecs[i].b)));
            check($sformatf("vec%0d_req_cycles", i), XLEN'(reqc), XLEN'(exp_lat(vecs[i].b) - 1));
            take_result();
        end

        // Grant withheld on every other requested cycle: one stall per op.
        run_mul(32'h12345678, 32'h10, 1, res, lat, reqc, stok);
        check("alt_gnt_result", res, 32'h23456780);
        check("alt_gnt_latency", XLEN'(lat), XLEN'(2 * (exp_lat(32'h10) - 1) + 1));
        check("alt_gnt_stall_stable", XLEN'(stok), XLEN'(1));
        take_result();

        // Consumer back-pressure: result held, new requests ignored.
        run_mul(32'd7, 32'd6, 0, res, lat, reqc, stok);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 32'd100 + 32'(i); in_b = 32'd3;
            @(negedge clk);
            check("hold_out_valid", XLEN'(out_valid), XLEN'(1));
            check("hold_out_result", out_result, 32'd42);
            check("hold_in_ready", XLEN'(in_ready), XLEN'(0));
        end
        in_valid = 1'b0;
        take_result();
        @(negedge clk);
        check("no_queued_req_alu_req", XLEN'(alu_req), XLEN'(0));
        check("no_queued_req_in_ready", XLEN'(in_ready), XLEN'(1));

        // Reset in the middle of a run.
        @(negedge clk);
        in_a = 32'd11; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n < 40; n++) begin
            alu_gnt = alu_req;
            @(negedge clk);
        end
        alu_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", XLEN'(in_ready), XLEN'(1));
        check("midrun_rst_alu_req", XLEN'(alu_req), XLEN'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", XLEN'(in_ready), XLEN'(1));
        check("after_rst_out_valid", XLEN'(out_valid), XLEN'(0));
        check("after_rst_alu_req", XLEN'(alu_req), XLEN'(0));
        run_mul(32'd3, 32'd4, 0, res, lat, reqc, stok);
        check("after_rst_result", res, 32'd12);
        take_result();

        // Randomized operands and grant pattern against plain multiplication.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_mul(a, b, 2, res, lat, reqc, stok);
            check($sformatf("rand%0d_result", i), res, a * b);
            check($sformatf("rand%0d_latency_ge", i), XLEN'(lat >= exp_lat(b)), XLEN'(1));
            check($sformatf("rand%0d_stall_stable", i), XLEN'(stok), XLEN'(1));
            take_result();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that produces the low XLEN bits of a×b by driving the shared integer ALU with add/sll/srl operations, one ALU operation per granted cycle. It sits beside the execute stage: the core hands it operands over a valid/ready request port and collects the product over a valid/ready response port. It borrows the ALU through a req/gnt pair, so the core keeps priority over the datapath.

## Interface
- XLEN, 32: operand/result width; iteration count equals XLEN.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer idle and able to accept.
- in_a  in  XLEN  multiplicand.
- in_b  in  XLEN  multiplier.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product.
- out_result  out  XLEN  low XLEN bits of in_a×in_b (sign-agnostic).
- alu_req  out  1  sequencer needs the ALU this cycle.
- alu_gnt  in  1  ALU is driven by the sequencer this cycle.
- alu_in1, alu_in2  out  XLEN  ALU operands.
- alu_op  out  4  ALU op code.
- alu_result  in  XLEN  combinational ALU result.
- alu_zero  in  1  ALU zero flag.

## Operation
- Registers: mcand, mplr, acc (XLEN each); cnt ($clog2(XLEN) bits); state.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE: in_ready=1. On in_valid: mcand<=in_a, mplr<=in_b, acc<=0, cnt<=0, go ADD.
- ADD: op 0000, in1=acc, in2=mplr[0] ? mcand : 0; on gnt acc<=alu_result, go SHL.
- SHL: op 0010, in1=mcand, in2=1; on gnt mcand<=alu_result, go SHR.
- SHR: op 0110, in1=mplr, in2=1; on gnt mplr<=alu_result, cnt<=cnt+1; go DONE if cnt==XLEN-1 (or early-exit condition, see Configuration), else ADD.
- ADD/SHL/SHR: alu_req=1; without alu_gnt no register changes and state holds (stall), ALU outputs stay stable.
- DONE: out_valid=1, out_result=acc; held stable until out_ready; on out_ready go IDLE.
- IDLE/DONE: alu_req=0, alu_op=0000, alu_in1=alu_in2=0.
- in_valid outside IDLE is ignored (in_ready=0); no queueing.
- Arithmetic modulo 2^XLEN; overflow discarded; result identical for signed and unsigned operands.

## Timing
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, alu_req=0, alu_op=0000, alu_in1/in2=0, acc/mcand/mplr/cnt=0. Reset mid-multiply abandons the operation; no output produced.
- Accept on edge where in_valid&&in_ready; ADD starts next cycle.
- Full run, gnt always 1: 3·XLEN sequencing cycles; out_valid rises 3·XLEN+1 cycles after accept edge (97 for XLEN=32).
- Each cycle with alu_req=1 and alu_gnt=0 adds exactly one cycle of latency.
- DONE→IDLE on the out_ready edge; next accept possible in the following cycle (no same-cycle turnaround).

## Configuration
- MUL_SEQ_EARLY_EXIT_EN defined: in SHR, also go DONE when alu_zero=1 (shifted multiplier zero); latency becomes 3·k+1 cycles, k = index of highest set bit of in_b plus 1 (k=1 for in_b=0).
- Undefined: alu_zero ignored; always XLEN iterations, fixed latency.

## Structure
- Shared alu_pkg: ALU op code localparams (ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001) and the sequencer state enum.
- Single module; no sub-module. ALU is external and instantiated by the parent together with the req/gnt mux.

## Test plan
- Reset asserted mid-run (cycle 40) -> next cycle IDLE, in_ready=1, out_valid=0, alu_req=0; new request 3×4 then yields 12.
- 7×6, gnt=1, macro off -> out_valid exactly 97 cycles after accept, out_result=42, alu_req high cycles 1–96.
- 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001; 0x80000000×2 -> 0x00000000.
- 0x12345678×0x10, alu_gnt low every other requested cycle -> latency 97+96 cycles, result 0x23456780.
- out_ready low 5 cycles after out_valid -> out_result/out_valid held, in_ready=0, in_valid pulses ignored; product taken on 6th cycle.
- Macro on: 5×1 -> out_valid 4 cycles after accept, result 5; 9×0 -> 4 cycles, result 0; 3×0x80000000 -> 97 cycles, 0x80000000.
